// File: rtl/mano_pkg.sv
// Shared encodings for the Mano control unit: register strobe indices, bus/ALU codes,
// opcodes and instruction bit positions.
package mano_pkg;

  localparam int REG_AR   = 0;
  localparam int REG_PC   = 1;
  localparam int REG_DR   = 2;
  localparam int REG_AC   = 3;
  localparam int REG_IR   = 4;
  localparam int REG_TR   = 5;
  localparam int REG_OUTR = 6;

  typedef enum logic [2:0] {
    BUS_NONE = 3'd0, BUS_AR = 3'd1, BUS_PC = 3'd2, BUS_DR = 3'd3,
    BUS_AC   = 3'd4, BUS_IR = 3'd5, BUS_TR = 3'd6, BUS_MEM = 3'd7
  } bus_sel_e;

  typedef enum logic [2:0] {
    ALU_NOP = 3'd0, ALU_AND = 3'd1, ALU_ADD = 3'd2, ALU_LDDR = 3'd3,
    ALU_CMA = 3'd4, ALU_CIR = 3'd5, ALU_CIL = 3'd6, ALU_INPR = 3'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    OP_AND = 3'd0, OP_ADD = 3'd1, OP_LDA = 3'd2, OP_STA = 3'd3,
    OP_BUN = 3'd4, OP_BSA = 3'd5, OP_ISZ = 3'd6, OP_REG = 3'd7
  } opcode_e;

  localparam int RR_CLA = 11;
  localparam int RR_CLE = 10;
  localparam int RR_CMA = 9;
  localparam int RR_CME = 8;
  localparam int RR_CIR = 7;
  localparam int RR_CIL = 6;
  localparam int RR_INC = 5;
  localparam int RR_SPA = 4;
  localparam int RR_SNA = 3;
  localparam int RR_SZA = 2;
  localparam int RR_SZE = 1;
  localparam int RR_HLT = 0;

  localparam int IO_INP = 11;
  localparam int IO_OUT = 10;
  localparam int IO_SKI = 9;
  localparam int IO_SKO = 8;
  localparam int IO_ION = 7;
  localparam int IO_IOF = 6;

  function automatic logic [11:0] onehot12(input int pos);
    return 12'd1 << pos;
  endfunction

endpackage

// File: rtl/mano_seq_counter.sv
// 4-bit sequence counter (clear beats increment, otherwise hold) with 4-to-16 timing decode.
// T outputs are a combinational decode of the registered count.
module mano_seq_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        sc_clr,
  input  logic        sc_inc,
  output logic [15:0] t
);

  logic [3:0] sc_q, sc_d;

  always_comb begin
    sc_d = sc_q;
    if (sc_clr) begin
      sc_d = 4'd0;
    end else if (sc_inc) begin
      sc_d = sc_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc_q <= 4'd0;
    end else begin
      sc_q <= sc_d;
    end
  end

  always_comb t = 16'd1 << sc_q;

endmodule

// File: rtl/mano_control_unit.sv
// Hardwired Mano control unit: all strobes decode combinationally from SC/flags/IR, acting at the edge that advances SC.
// IO_INT_EN adds the I/O instructions and the interrupt cycle; without it D=7,I=1 is a NOP.
module mano_control_unit
  import mano_pkg::*;
(
  input  logic        CLK,
  input  logic        CLR,
  input  logic [15:0] IR,
  input  logic        AC_SIGN,
  input  logic        AC_ZERO,
  input  logic        DR_ZERO,
  input  logic        E,
  input  logic        FGI,
  input  logic        FGO,
  output logic [6:0]  LD,
  output logic [6:0]  INR,
  output logic [6:0]  CLRR,
  output logic [2:0]  BUS_SEL,
  output logic        MEM_RD,
  output logic        MEM_WR,
  output logic [2:0]  ALU_OP,
  output logic        E_CLR,
  output logic        E_CMP,
  output logic        FGI_CLR,
  output logic        FGO_CLR,
  output logic        RUN,
  output logic        IEN
);

  logic [15:0] t;
  logic        sc_clr, sc_inc;
  logic        s_q, s_d, ien_q, ien_d, r_q, r_d, i_q, i_d;
  logic        intr_cyc;
  opcode_e     d;

  assign d = opcode_e'(IR[14:12]);

`ifdef IO_INT_EN
  assign intr_cyc = r_q & (|t[2:0]);
`else
  assign intr_cyc = 1'b0;
  logic unused_io_flags;
  assign unused_io_flags = FGI ^ FGO;
`endif

  mano_seq_counter u_sc (
    .clk    (CLK),
    .rst    (CLR),
    .sc_clr (sc_clr),
    .sc_inc (sc_inc),
    .t      (t)
  );

  assign sc_inc = s_q & ~sc_clr;
  assign RUN    = s_q;
  assign IEN    = ien_q;

  always_comb begin
    LD = '0; INR = '0; CLRR = '0;
    BUS_SEL = BUS_NONE; ALU_OP = ALU_NOP;
    MEM_RD = 1'b0; MEM_WR = 1'b0;
    E_CLR = 1'b0; E_CMP = 1'b0; FGI_CLR = 1'b0; FGO_CLR = 1'b0;
    sc_clr = 1'b0;
    s_d = s_q; ien_d = ien_q; r_d = r_q; i_d = i_q;
    // A halted machine freezes completely; only CLR gets it going again.
    if (s_q) begin
      if (|t[15:7]) begin
        sc_clr = 1'b1;
      end else if (intr_cyc) begin
        if (t[0]) begin
          CLRR[REG_AR] = 1'b1; BUS_SEL = BUS_PC; LD[REG_TR] = 1'b1;
        end else if (t[1]) begin
          BUS_SEL = BUS_TR; MEM_WR = 1'b1; CLRR[REG_PC] = 1'b1;
        end else begin
          INR[REG_PC] = 1'b1; ien_d = 1'b0; r_d = 1'b0; sc_clr = 1'b1;
        end
      end else if (t[0]) begin
        BUS_SEL = BUS_PC; LD[REG_AR] = 1'b1;
      end else if (t[1]) begin
        BUS_SEL = BUS_MEM; MEM_RD = 1'b1; LD[REG_IR] = 1'b1; INR[REG_PC] = 1'b1;
      end else if (t[2]) begin
        BUS_SEL = BUS_IR; LD[REG_AR] = 1'b1; i_d = IR[15];
      end else if (t[3]) begin
        if (d == OP_REG) begin
          sc_clr = 1'b1;
          // Only exact one-hot patterns act; anything else falls through as a NOP.
          if (!i_q) begin
            case (IR[11:0])
              onehot12(RR_CLA): CLRR[REG_AC] = 1'b1;
              onehot12(RR_CLE): E_CLR = 1'b1;
              onehot12(RR_CMA): begin ALU_OP = ALU_CMA; LD[REG_AC] = 1'b1; end
              onehot12(RR_CME): E_CMP = 1'b1;
              onehot12(RR_CIR): begin ALU_OP = ALU_CIR; LD[REG_AC] = 1'b1; end
              onehot12(RR_CIL): begin ALU_OP = ALU_CIL; LD[REG_AC] = 1'b1; end
              onehot12(RR_INC): INR[REG_AC] = 1'b1;
              onehot12(RR_SPA): INR[REG_PC] = ~AC_SIGN;
              onehot12(RR_SNA): INR[REG_PC] = AC_SIGN;
              onehot12(RR_SZA): INR[REG_PC] = AC_ZERO;
              onehot12(RR_SZE): INR[REG_PC] = ~E;
              onehot12(RR_HLT): s_d = 1'b0;
              default: ;
            endcase
          end else begin
`ifdef IO_INT_EN
            case (IR[11:0])
              onehot12(IO_INP): begin ALU_OP = ALU_INPR; LD[REG_AC] = 1'b1; FGI_CLR = 1'b1; end
              onehot12(IO_OUT): begin BUS_SEL = BUS_AC; LD[REG_OUTR] = 1'b1; FGO_CLR = 1'b1; end
              onehot12(IO_SKI): INR[REG_PC] = FGI;
              onehot12(IO_SKO): INR[REG_PC] = FGO;
              onehot12(IO_ION): ien_d = 1'b1;
              onehot12(IO_IOF): ien_d = 1'b0;
              default: ;
            endcase
`endif
          end
        end else if (i_q) begin
          BUS_SEL = BUS_MEM; MEM_RD = 1'b1; LD[REG_AR] = 1'b1;
        end
      end else begin
        case (d)
          OP_AND, OP_ADD, OP_LDA: begin
            if (t[4]) begin
              BUS_SEL = BUS_MEM; MEM_RD = 1'b1; LD[REG_DR] = 1'b1;
            end else begin
              ALU_OP = (d == OP_AND) ? ALU_AND : (d == OP_ADD) ? ALU_ADD : ALU_LDDR;
              LD[REG_AC] = 1'b1; sc_clr = 1'b1;
            end
          end
          OP_STA: begin BUS_SEL = BUS_AC; MEM_WR = 1'b1; sc_clr = 1'b1; end
          OP_BUN: begin BUS_SEL = BUS_AR; LD[REG_PC] = 1'b1; sc_clr = 1'b1; end
          OP_BSA: begin
            if (t[4]) begin
              BUS_SEL = BUS_PC; MEM_WR = 1'b1; INR[REG_AR] = 1'b1;
            end else begin
              BUS_SEL = BUS_AR; LD[REG_PC] = 1'b1; sc_clr = 1'b1;
            end
          end
          OP_ISZ: begin
            if (t[4]) begin
              BUS_SEL = BUS_MEM; MEM_RD = 1'b1; LD[REG_DR] = 1'b1;
            end else if (t[5]) begin
              INR[REG_DR] = 1'b1;
            end else begin
              BUS_SEL = BUS_DR; MEM_WR = 1'b1; INR[REG_PC] = DR_ZERO; sc_clr = 1'b1;
            end
          end
          default: sc_clr = 1'b1;
        endcase
      end
`ifdef IO_INT_EN
      if (ien_q && (FGI || FGO) && !(|t[2:0])) r_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      s_q <= 1'b1; ien_q <= 1'b0; r_q <= 1'b0; i_q <= 1'b0;
    end else begin
      s_q <= s_d; ien_q <= ien_d; r_q <= r_d; i_q <= i_d;
    end
  end

endmodule

// File: tb/tb_mano_control_unit.sv
// Bench for mano_control_unit: per-instruction expected micro-op sequences built from the
// machine's instruction definitions, compared every cycle against the DUT outputs.
module tb_mano_control_unit;

  logic        CLK = 1'b0;
  logic        CLR;
  logic [15:0] IR;
  logic        AC_SIGN, AC_ZERO, DR_ZERO, E, FGI, FGO;
  logic [6:0]  LD, INR, CLRR;
  logic [2:0]  BUS_SEL, ALU_OP;
  logic        MEM_RD, MEM_WR, E_CLR, E_CMP, FGI_CLR, FGO_CLR, RUN, IEN;

  mano_control_unit dut (
    .CLK(CLK), .CLR(CLR), .IR(IR), .AC_SIGN(AC_SIGN), .AC_ZERO(AC_ZERO),
    .DR_ZERO(DR_ZERO), .E(E), .FGI(FGI), .FGO(FGO),
    .LD(LD), .INR(INR), .CLRR(CLRR), .BUS_SEL(BUS_SEL), .MEM_RD(MEM_RD),
    .MEM_WR(MEM_WR), .ALU_OP(ALU_OP), .E_CLR(E_CLR), .E_CMP(E_CMP),
    .FGI_CLR(FGI_CLR), .FGO_CLR(FGO_CLR), .RUN(RUN), .IEN(IEN)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [6:0] ld, inr, clrr;
    logic [2:0] bus, alu;
    logic rd, wr, eclr, ecmp, fgiclr, fgoclr, run, ien;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   m_ien  = 1'b0;

  function automatic obs_t idle();
    obs_t c;
    c = '0;
    c.run = 1'b1;
    c.ien = m_ien;
    return c;
  endfunction

  function automatic obs_t fetch_t0();
    obs_t c;
    c = idle();
    c.bus = 3'd2;
    c.ld[0] = 1'b1;
    return c;
  endfunction

  task automatic check(input string tag, input obs_t exp);
    obs_t got;
    got = {LD, INR, CLRR, BUS_SEL, ALU_OP, MEM_RD, MEM_WR, E_CLR, E_CMP,
           FGI_CLR, FGO_CLR, RUN, IEN};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: the cycle-by-cycle micro-operations of one instruction.
  task automatic build(input logic [15:0] ir);
    obs_t c;
    int   op;
    bit   ind;
    op  = int'(ir[14:12]);
    ind = ir[15];
    exp_q.push_back(fetch_t0());
    c = idle(); c.bus = 3'd7; c.rd = 1'b1; c.ld[4] = 1'b1; c.inr[1] = 1'b1; exp_q.push_back(c);
    c = idle(); c.bus = 3'd5; c.ld[0] = 1'b1; exp_q.push_back(c);
    c = idle();
    if (op == 7) begin
      if (!ind) begin
        case (ir[11:0])
          12'h800: c.clrr[3] = 1'b1;
          12'h400: c.eclr = 1'b1;
          12'h200: begin c.alu = 3'd4; c.ld[3] = 1'b1; end
          12'h100: c.ecmp = 1'b1;
          12'h080: begin c.alu = 3'd5; c.ld[3] = 1'b1; end
          12'h040: begin c.alu = 3'd6; c.ld[3] = 1'b1; end
          12'h020: c.inr[3] = 1'b1;
          12'h010: c.inr[1] = !AC_SIGN;
          12'h008: c.inr[1] = AC_SIGN;
          12'h004: c.inr[1] = AC_ZERO;
          12'h002: c.inr[1] = !E;
          default: ;
        endcase
      end
      exp_q.push_back(c);
`ifdef IO_INT_EN
      if (ind && ir[11:0] == 12'h080) m_ien = 1'b1;
`endif
    end else begin
      if (ind) begin c.bus = 3'd7; c.rd = 1'b1; c.ld[0] = 1'b1; end
      exp_q.push_back(c);
      c = idle();
      case (op)
        0, 1, 2: begin
          c.bus = 3'd7; c.rd = 1'b1; c.ld[2] = 1'b1; exp_q.push_back(c);
          c = idle(); c.alu = 3'(op + 1); c.ld[3] = 1'b1; exp_q.push_back(c);
        end
        3: begin c.bus = 3'd4; c.wr = 1'b1; exp_q.push_back(c); end
        4: begin c.bus = 3'd1; c.ld[1] = 1'b1; exp_q.push_back(c); end
        5: begin
          c.bus = 3'd2; c.wr = 1'b1; c.inr[0] = 1'b1; exp_q.push_back(c);
          c = idle(); c.bus = 3'd1; c.ld[1] = 1'b1; exp_q.push_back(c);
        end
        default: begin
          c.bus = 3'd7; c.rd = 1'b1; c.ld[2] = 1'b1; exp_q.push_back(c);
          c = idle(); c.inr[2] = 1'b1; exp_q.push_back(c);
          c = idle(); c.bus = 3'd3; c.wr = 1'b1; c.inr[1] = DR_ZERO; exp_q.push_back(c);
        end
      endcase
    end
  endtask

  // Entered one time unit after the edge that starts T0; leaves at the same phase.
  task automatic run_instr(input logic [15:0] ir);
    obs_t e;
    int   k;
    k  = 0;
    IR = ir;
    build(ir);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      #1;
      check($sformatf("ir%h_t%0d", ir, k), e);
      k++;
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    obs_t c;
    obs_t e;
    logic [15:0] rir;
    logic [11:0] rr;
    CLR = 1'b1; IR = 16'h0000;
    AC_SIGN = 1'b0; AC_ZERO = 1'b0; DR_ZERO = 1'b0; E = 1'b0; FGI = 1'b0; FGO = 1'b0;
    #2;
    check("reset_t0", fetch_t0());
    @(posedge CLK); #1;
    check("reset_hold", fetch_t0());
    CLR = 1'b0;

    run_instr(16'h7800);
    run_instr(16'h2005);
    run_instr(16'hA005);
    DR_ZERO = 1'b1; run_instr(16'h6010);
    DR_ZERO = 1'b0; run_instr(16'h6010);
    run_instr(16'h5010);
    run_instr(16'hC123);
    AC_SIGN = 1'b1; run_instr(16'h7008);
    AC_SIGN = 1'b0; run_instr(16'h7008);

    for (int n = 0; n < 40; n++) begin
      AC_SIGN = 1'($urandom); AC_ZERO = 1'($urandom);
      DR_ZERO = 1'($urandom); E = 1'($urandom);
      FGI = 1'($urandom); FGO = 1'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        rr = 12'h001 << $urandom_range(1, 11);
        if ($urandom_range(0, 7) == 0) rr = 12'h0C0;
        rir = {4'h7, rr};
`ifndef IO_INT_EN
        if ($urandom_range(0, 3) == 0) rir[15] = 1'b1;
`endif
      end else begin
        rir = {1'($urandom), 3'($urandom_range(0, 6)), 12'($urandom)};
      end
      run_instr(rir);
    end
    FGI = 1'b0; FGO = 1'b0;

    // Abort STA at T4: reset must suppress the store and restart at T0.
    IR = 16'h3005;
    build(IR);
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      #1;
      check($sformatf("sta_pre_t%0d", k), e);
      @(posedge CLK); #1;
    end
    exp_q.delete();
    CLR = 1'b1;
    #1;
    check("sta_abort", fetch_t0());
    @(posedge CLK); #1;
    CLR = 1'b0;
    run_instr(16'h1007);

    // Halt: everything frozen until CLR.
    run_instr(16'h7001);
    c = '0;
    for (int k = 0; k < 20; k++) begin
      #1;
      check($sformatf("halted_%0d", k), c);
      @(posedge CLK); #1;
    end
    CLR = 1'b1;
    #1;
    check("restart_t0", fetch_t0());
    @(posedge CLK); #1;
    CLR = 1'b0;
    run_instr(16'h7020);

`ifdef IO_INT_EN
    run_instr(16'hF080);
    FGI = 1'b1;
    run_instr(16'h3010);
    c = idle(); c.clrr[0] = 1'b1; c.bus = 3'd2; c.ld[5] = 1'b1;
    #1; check("intr_t0", c); @(posedge CLK); #1;
    c = idle(); c.bus = 3'd6; c.wr = 1'b1; c.clrr[1] = 1'b1;
    #1; check("intr_t1", c); @(posedge CLK); #1;
    c = idle(); c.inr[1] = 1'b1;
    #1; check("intr_t2", c); @(posedge CLK); #1;
    m_ien = 1'b0;
    FGI = 1'b0;
    run_instr(16'h7800);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
